// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             ovf;

  modport master (output start, a, b, b_in, input busy, done, diff, b_out, ovf);
  modport slave  (input start, a, b, b_in, output busy, done, diff, b_out, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - b_in, LSB first through one
// full-subtractor cell with a registered borrow, behind a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                reset,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    cnt_r;
  logic             br_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic [WIDTH-1:0] diff_r;
  logic             b_out_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic             d_s;
  logic             br_nxt_s;
  logic [WIDTH-1:0] r_nxt_s;
  logic             ovf_s;

  function automatic logic borrow_f(input logic a0, input logic b0, input logic br);
    return (~a0 & b0) | (~a0 & br) | (b0 & br);
  endfunction

  // Next-state decode; start only matters in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_s = RUN;
        else           state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == CNT_LAST) state_s = DONE;
        else                   state_s = RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Single full-subtractor cell plus the result shifter feeding it.
  always_comb begin
    d_s                = a_sh_r[0] ^ b_sh_r[0] ^ br_r;
    br_nxt_s           = borrow_f(a_sh_r[0], b_sh_r[0], br_r);
    r_nxt_s            = r_r >> 1;
    r_nxt_s[WIDTH-1]   = d_s;
    ovf_s              = (a_msb_r != b_msb_r) && (r_nxt_s[WIDTH-1] != a_msb_r);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Operand capture, bit-serial datapath, result and handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      r_r     <= '0;
      cnt_r   <= '0;
      br_r    <= 1'b0;
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      diff_r  <= '0;
      b_out_r <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r <= (state_s == RUN);
      done_r <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            br_r    <= bus.b_in;
            r_r     <= '0;
            cnt_r   <= '0;
            a_msb_r <= bus.a[WIDTH-1];
            b_msb_r <= bus.b[WIDTH-1];
          end else begin
            cnt_r <= cnt_r;
          end
        end
        RUN: begin
          a_sh_r <= a_sh_r >> 1;
          b_sh_r <= b_sh_r >> 1;
          br_r   <= br_nxt_s;
          r_r    <= r_nxt_s;
          cnt_r  <= cnt_r + CNT_ONE;
          // Results are only published on the last bit so they stay stable through RUN.
          if (cnt_r == CNT_LAST) begin
            diff_r  <= r_nxt_s;
            b_out_r <= br_nxt_s;
            ovf_r   <= ovf_s;
          end else begin
            diff_r <= diff_r;
          end
        end
        DONE:    cnt_r <= '0;
        default: cnt_r <= '0;
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.diff  = diff_r;
  assign bus.b_out = b_out_r;
  assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed cases at WIDTH=4 and
// start-held random streams at WIDTH=1, 4 and 8 checked against a signed/unsigned model.
module tb_serial_subtractor;

  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NI-1:0] start_v;
  logic [31:0]   a_drv;
  logic [31:0]   b_drv;
  logic          bin_drv;

  logic [31:0]   diff_v [NI];
  logic [NI-1:0] busy_v;
  logic [NI-1:0] done_v;
  logic [NI-1:0] bout_v;
  logic [NI-1:0] ovf_v;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  logic [33:0] sb_q [$];

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(1)) if_w1 ();
  serial_subtractor_if #(.WIDTH(4)) if_w4 ();
  serial_subtractor_if #(.WIDTH(8)) if_w8 ();

  assign if_w1.start = start_v[0];
  assign if_w4.start = start_v[1];
  assign if_w8.start = start_v[2];
  assign if_w1.a = a_drv[0:0];
  assign if_w4.a = a_drv[3:0];
  assign if_w8.a = a_drv[7:0];
  assign if_w1.b = b_drv[0:0];
  assign if_w4.b = b_drv[3:0];
  assign if_w8.b = b_drv[7:0];
  assign if_w1.b_in = bin_drv;
  assign if_w4.b_in = bin_drv;
  assign if_w8.b_in = bin_drv;

  assign diff_v[0] = {31'd0, if_w1.diff};
  assign diff_v[1] = {28'd0, if_w4.diff};
  assign diff_v[2] = {24'd0, if_w8.diff};
  assign busy_v = {if_w8.busy, if_w4.busy, if_w1.busy};
  assign done_v = {if_w8.done, if_w4.done, if_w1.done};
  assign bout_v = {if_w8.b_out, if_w4.b_out, if_w1.b_out};
  assign ovf_v  = {if_w8.ovf, if_w4.ovf, if_w1.ovf};

  serial_subtractor #(.WIDTH(1)) u_w1 (.clk(clk), .reset(reset), .bus(if_w1.slave));
  serial_subtractor #(.WIDTH(4)) u_w4 (.clk(clk), .reset(reset), .bus(if_w4.slave));
  serial_subtractor #(.WIDTH(8)) u_w8 (.clk(clk), .reset(reset), .bus(if_w8.slave));

  function automatic int width_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  // Reference: unsigned borrow and signed-range overflow computed in 64-bit arithmetic.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic bin);
    longint ua, ub, lb, sa, sb, res, full, mask, lim;
    logic [31:0] d;
    logic bo, ov;
    ua = longint'(a);
    ub = longint'(b);
    lb = 0;
    if (bin) lb = 1;
    mask = (longint'(1) << w) - 1;
    full = ua - ub - lb;
    d    = 32'(full & mask);
    bo   = (ua < ub + lb);
    lim  = longint'(1) << (w - 1);
    sa   = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb   = b[w-1] ? ub - (longint'(1) << w) : ub;
    res  = sa - sb - lb;
    ov   = (res > lim - 1) || (res < -lim);
    return {ov, bo, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until done (bounded), then pops the scoreboard and compares the result.
  task automatic collect(input int k, input string tag, output int lat);
    logic [33:0] exp;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done_v[k] && lat < 64);
    if (!done_v[k]) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else if (sb_q.size() == 0) begin
      check({tag, "_unexpected_done"}, 64'd1, 64'd0);
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_diff"},  64'(diff_v[k]), 64'(exp[31:0]));
      check({tag, "_b_out"}, 64'(bout_v[k]), 64'(exp[32]));
      check({tag, "_ovf"},   64'(ovf_v[k]),  64'(exp[33]));
      check({tag, "_busy_at_done"}, 64'(busy_v[k]), 64'd0);
    end
  endtask

  task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic bin, input string tag);
    int w, lat;
    w = width_of(k);
    a_drv = a;
    b_drv = b;
    bin_drv = bin;
    start_v[k] = 1'b1;
    sb_q.push_back(model(w, a, b, bin));
    tick();
    start_v[k] = 1'b0;
    a_drv = ~a;
    b_drv = ~b;
    bin_drv = ~bin;
    check({tag, "_busy"}, 64'(busy_v[k]), 64'd1);
    collect(k, tag, lat);
    check({tag, "_latency"}, 64'(lat), 64'(w));
    tick();
    check({tag, "_done_pulse"}, 64'(done_v[k]), 64'd0);
  endtask

  initial begin
    int lat, w;
    logic [31:0] msk;
    logic seen_done;

    reset = 1'b1;
    start_v = '0;
    a_drv = '0;
    b_drv = '0;
    bin_drv = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_busy",  64'(busy_v[1]), 64'd0);
    check("rst_done",  64'(done_v[1]), 64'd0);
    check("rst_diff",  64'(diff_v[1]), 64'd0);
    check("rst_b_out", 64'(bout_v[1]), 64'd0);
    check("rst_ovf",   64'(ovf_v[1]),  64'd0);

    do_op(1, 32'd9, 32'd3, 1'b0, "t1");
    do_op(1, 32'd3, 32'd9, 1'b0, "t2");
    do_op(1, 32'd0, 32'd0, 1'b1, "t3");

    // Second start during RUN is dropped; previous result (0xF) holds meanwhile.
    a_drv = 32'd5;
    b_drv = 32'd2;
    bin_drv = 1'b0;
    start_v[1] = 1'b1;
    sb_q.push_back(model(4, 32'd5, 32'd2, 1'b0));
    tick();
    start_v[1] = 1'b0;
    check("t5_hold_diff", 64'(diff_v[1]), 64'hF);
    a_drv = 32'd15;
    b_drv = 32'd0;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    check("t5_hold_diff2", 64'(diff_v[1]), 64'hF);
    collect(1, "t5_ignored", lat);
    tick();

    // Reset during the second RUN cycle aborts with no done pulse.
    a_drv = 32'd9;
    b_drv = 32'd3;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_abort_busy", 64'(busy_v[1]), 64'd0);
    check("t5_abort_done", 64'(done_v[1]), 64'd0);
    check("t5_abort_diff", 64'(diff_v[1]), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_v[1]) seen_done = 1'b1;
    end
    check("t5_abort_no_done", 64'(seen_done), 64'd0);

    do_op(1, 32'd8, 32'd1, 1'b0, "t4a");
    do_op(1, 32'd8, 32'd8, 1'b0, "t4b");

    // Back-to-back stream with start held: period WIDTH+2 once running.
    for (int k = 0; k < NI; k++) begin
      w = width_of(k);
      msk = (32'd1 << w) - 32'd1;
      a_drv = $urandom & msk;
      b_drv = $urandom & msk;
      bin_drv = 1'($urandom_range(1, 0));
      sb_q.push_back(model(w, a_drv, b_drv, bin_drv));
      start_v[k] = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        collect(k, "rand", lat);
        check("rand_period", 64'(lat), (i == 0) ? 64'(w + 1) : 64'(w + 2));
        if (i < 999) begin
          a_drv = $urandom & msk;
          b_drv = $urandom & msk;
          bin_drv = 1'($urandom_range(1, 0));
          sb_q.push_back(model(w, a_drv, b_drv, bin_drv));
        end else begin
          start_v[k] = 1'b0;
        end
      end
      repeat (2) tick();
      check("rand_queue_empty", 64'(sb_q.size()), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
